// File: rtl/llpm_channel_fifo.sv
// Registered FIFO for one LLPM channel.
// Breaks select data/backpressure paths; all outputs come from state.
module llpm_channel_fifo #(
  parameter int Width      = 8,
  parameter int Depth      = 4,
  parameter int CLog2Depth = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [Width-1:0]      x,
  input  logic                  x_valid,
  output logic                  x_bp,
  output logic [Width-1:0]      a,
  output logic                  a_valid,
  input  logic                  a_bp,
  output logic [CLog2Depth:0]   count
);

  localparam logic [CLog2Depth:0] Full = (CLog2Depth+1)'(Depth);

  logic [Width-1:0]      mem [Depth];
  logic [CLog2Depth-1:0] wr_ptr;
  logic [CLog2Depth-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  assign x_bp    = (count == Full);
  assign a_valid = (count != '0);
  assign a       = mem[rd_ptr];

  assign push = x_valid & ~x_bp;
  assign pop  = a_valid & ~a_bp;

  // Storage is not reset; a push on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_llpm_channel_fifo.sv
// Directed vector bench for llpm_channel_fifo.
// Each vector holds inputs and the outputs expected in that same cycle.
module tb_llpm_channel_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] x;
  logic       x_valid;
  logic       x_bp;
  logic [7:0] a;
  logic       a_valid;
  logic       a_bp;
  logic [2:0] count;

  llpm_channel_fifo #(
    .Width(8),
    .Depth(4),
    .CLog2Depth(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .x(x),
    .x_valid(x_valid),
    .x_bp(x_bp),
    .a(a),
    .a_valid(a_valid),
    .a_bp(a_bp),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       xv;
    logic [7:0] xd;
    logic       abp;
    logic       chk;
    int         ecount;
    logic       ebp;
    logic       eav;
    logic [7:0] ea;
  } vec_t;

  vec_t vecs[$];
  int   nvec;
  int   nerr;

  task automatic add(input logic rst, input logic xv, input logic [7:0] xd,
                     input logic abp, input logic chk, input int ec,
                     input logic ebp, input logic eav, input logic [7:0] ea);
    vec_t v;
    v.rst = rst; v.xv = xv; v.xd = xd; v.abp = abp; v.chk = chk;
    v.ecount = ec; v.ebp = ebp; v.eav = eav; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input int act,
                     input int exp);
    if (act != exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b1; x = '0; x_valid = 1'b0; a_bp = 1'b0;

    // reset and idle
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    // fill to full, 0x55 held
    add(0, 1, 8'h11, 1, 1, 0, 0, 0, 8'h00);
    add(0, 1, 8'h22, 1, 1, 1, 0, 1, 8'h11);
    add(0, 1, 8'h33, 1, 1, 2, 0, 1, 8'h11);
    add(0, 1, 8'h44, 1, 1, 3, 0, 1, 8'h11);
    add(0, 1, 8'h55, 1, 1, 4, 1, 1, 8'h11);
    // drain; full+pop keeps x_bp, 0x55 wraps to index 0
    add(0, 1, 8'h55, 0, 1, 4, 1, 1, 8'h11);
    add(0, 1, 8'h55, 0, 1, 3, 0, 1, 8'h22);
    add(0, 0, 8'h00, 0, 1, 3, 0, 1, 8'h33);
    add(0, 0, 8'h00, 0, 1, 2, 0, 1, 8'h44);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1, 8'h55);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    // preload two, then streaming push/pop
    add(0, 1, 8'h90, 1, 1, 0, 0, 0, 8'h00);
    add(0, 1, 8'h91, 1, 1, 1, 0, 1, 8'h90);
    for (int i = 0; i < 8; i++) begin
      add(0, 1, 8'hA0 + 8'(i), 0, 1, 2, 0, 1,
          (i == 0) ? 8'h90 : (i == 1) ? 8'h91 : 8'hA0 + 8'(i - 2));
    end
    // full plus pop in the same cycle
    add(0, 1, 8'hB0, 1, 1, 2, 0, 1, 8'hA6);
    add(0, 1, 8'hB1, 1, 1, 3, 0, 1, 8'hA6);
    add(0, 1, 8'hBB, 0, 1, 4, 1, 1, 8'hA6);
    add(0, 1, 8'hBB, 1, 1, 3, 0, 1, 8'hA7);
    add(0, 0, 8'h00, 1, 1, 4, 1, 1, 8'hA7);
    // mid-stream reset at count 3
    add(0, 0, 8'h00, 0, 1, 4, 1, 1, 8'hA7);
    add(1, 1, 8'hCC, 0, 1, 3, 0, 1, 8'hB0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
    add(0, 1, 8'hDD, 1, 1, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1, 8'hDD);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset   = vecs[i].rst;
      x_valid = vecs[i].xv;
      x       = vecs[i].xd;
      a_bp    = vecs[i].abp;
      #1;
      nvec++;
      if (vecs[i].chk) begin
        cmp("count", i, int'(count), vecs[i].ecount);
        cmp("x_bp", i, int'(x_bp), int'(vecs[i].ebp));
        cmp("a_valid", i, int'(a_valid), int'(vecs[i].eav));
        if (vecs[i].eav) begin
          cmp("a", i, int'(a), int'(vecs[i].ea));
        end
      end
    end

    // hand sequence: stream pushes until x_bp, bounded
    begin
      int  k;
      bit  seen;
      k = 0;
      seen = 1'b0;
      a_bp = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        #1;
        if (x_bp) begin
          seen = 1'b1;
          break;
        end
        x_valid = 1'b1;
        x = 8'hE0 + 8'(k);
        k++;
      end
      x_valid = 1'b0;
      nvec++;
      cmp("fill_seen", 100, int'(seen), 1);
      cmp("fill_pushes", 100, k, 4);
      cmp("fill_count", 100, int'(count), 4);
      cmp("fill_head", 100, int'(a), 8'hE0);
      @(negedge clk);
      #1;
      cmp("hold_head", 101, int'(a), 8'hE0);
      cmp("hold_count", 101, int'(count), 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
